tlut_seq_ctrl: RTL and testbench
================================

// Module: tlut_seq_ctrl
// PURPOSE
//   Job sequencer for one TLUT SIMD cell (input/weight regs, cmp, weight accumulators,
//   product regs, adder tree, rollover counter). Accepts a job via valid/ready, strobes
//   operand load, drives cell enable for one full temporal sweep of 2**INPUT_WIDTH cycles,
//   waits out adder-tree latency, then pulses result capture and holds out_valid until taken.
//   Supports pause (stall mid-sweep) and abort (flush cell, return to IDLE).
// PARAMETERS
//   INPUT_WIDTH  3   input bit width; sweep length RUN_LEN = 2**INPUT_WIDTH cycles
//   TREE_LAT     2   adder-tree pipeline latency in cycles (>=0)
//   JOB_W        16  width of completed-job counter
// PORTS
//   clk          in   1            clock, all logic rising-edge
//   rst          in   1            asynchronous reset, active-high
//   start_valid  in   1            job request
//   start_ready  out  1            job accepted when start_valid & start_ready
//   pause        in   1            stall sweep (RUN only)
//   abort        in   1            cancel current job, any state
//   out_ready    in   1            consumer accepts result
//   out_valid    out  1            result held in capture register is valid
//   cell_load    out  1            1-cycle strobe: load operand registers
//   cell_enable  out  1            drives cell enable (cmp, accumulators, rollover counter)
//   cell_flush   out  1            1-cycle strobe: clear cell state after abort
//   res_capture  out  1            1-cycle strobe: capture accumulated_mult into result reg
//   busy         out  1            state != IDLE
//   state_o      out  3            IDLE=0 LOAD=1 RUN=2 DRAIN=3 HOLD=4
//   job_cnt      out  JOB_W        completed jobs (out_valid & out_ready handshakes)
// BEHAVIOUR
//   Reset: state=IDLE, run_cnt=0, drain_cnt=0, job_cnt=0; all 1-bit outputs 0 except
//     start_ready=1 (combinational from IDLE).
//   start_ready = (state==IDLE) | (state==HOLD & out_ready); forced 0 while abort=1.
//   IDLE: on start handshake -> LOAD.
//   LOAD: cell_load=1 for exactly this cycle; run_cnt<=0; -> RUN.
//   RUN: cell_enable = ~pause. When enabled run_cnt increments; when run_cnt==RUN_LEN-1
//     and not paused -> DRAIN. Paused cycles: run_cnt holds, enable low, no state change.
//     Exactly RUN_LEN enabled cycles per job regardless of pause pattern.
//   DRAIN: cell_enable=0; drain_cnt counts 0..TREE_LAT; res_capture=1 on drain_cnt==TREE_LAT,
//     -> HOLD. Total DRAIN duration TREE_LAT+1 cycles. pause ignored.
//   HOLD: out_valid=1 until out_ready. On handshake job_cnt+1 (wraps at 2**JOB_W);
//     if start_valid same cycle -> LOAD (back-to-back, no IDLE bubble), else -> IDLE.
//   abort (highest priority, sampled every cycle): if state!=IDLE -> IDLE next cycle,
//     cell_flush=1 for that one cycle (registered), run_cnt/drain_cnt cleared, out_valid
//     drops, job_cnt unchanged. abort in IDLE: no effect, no flush.
//   Simultaneous abort & out_ready in HOLD: abort wins, job not counted.
//   rst asserted mid-job: immediate return to reset values; no strobes emitted.
//   All strobes (cell_load, res_capture, cell_flush) are registered-clean single pulses.
//   Latency start-handshake -> out_valid = 1 + RUN_LEN + TREE_LAT + 1 + pause cycles.
// TESTING (INPUT_WIDTH=3, TREE_LAT=2 -> RUN_LEN=8)
//   Start at cycle 0, no pause -> cell_load @1, cell_enable @2..9, res_capture @12,
//     out_valid from 13; out_ready @15 -> job_cnt=1, IDLE @16.
//   Pause high cycles 4..6 -> exactly 8 enable cycles (2,3,7..12), res_capture @15.
//   HOLD with out_ready & start_valid same cycle -> next cycle LOAD, cell_load=1, job_cnt+1.
//   abort @6 in RUN -> IDLE @7 with cell_flush=1 @7, no res_capture, job_cnt unchanged.
//   abort & out_ready together in HOLD -> out_valid 0 next cycle, job_cnt unchanged.
//   rst pulse mid-DRAIN -> all outputs reset immediately, start_ready=1, no capture;
//     JOB_W=2, 5 jobs completed -> job_cnt=1 (wrap).

Source files
------------

// File: rtl/tlut_seq_ctrl.sv
// Job sequencer for one TLUT SIMD cell: operand load, one full temporal sweep,
// adder-tree drain, result capture and result hand-off, with pause and abort.
module tlut_seq_ctrl #(
    parameter int INPUT_WIDTH = 3,
    parameter int TREE_LAT    = 2,
    parameter int JOB_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             pause,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             cell_load,
    output logic             cell_enable,
    output logic             cell_flush,
    output logic             res_capture,
    output logic             busy,
    output logic [2:0]       state_o,
    output logic [JOB_W-1:0] job_cnt
);

    localparam int DRAIN_W = (TREE_LAT > 0) ? $clog2(TREE_LAT + 1) : 1;
    localparam logic [INPUT_WIDTH-1:0] RUN_LAST   = {INPUT_WIDTH{1'b1}};
    localparam logic [DRAIN_W-1:0]     DRAIN_LAST = DRAIN_W'(TREE_LAT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] run_cnt_q, run_cnt_d;
    logic [DRAIN_W-1:0]     drain_cnt_q, drain_cnt_d;
    logic [JOB_W-1:0]       job_cnt_q, job_cnt_d;
    logic                   load_q, load_d;
    logic                   capture_q, capture_d;
    logic                   flush_q, flush_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;
    logic                   start_ready_s;
    logic                   cell_enable_s;
    logic [DRAIN_W-1:0]     drain_nxt_s;

    // Next-state, counter and strobe computation; abort overrides every state but IDLE.
    always_comb begin
        state_d       = state_q;
        run_cnt_d     = run_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        job_cnt_d     = job_cnt_q;
        load_d        = 1'b0;
        capture_d     = 1'b0;
        flush_d       = 1'b0;
        drain_nxt_s   = drain_cnt_q + DRAIN_W'(1);
        start_ready_s = ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready)) && !abort;
        cell_enable_s = (state_q == ST_RUN) && !pause;

        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            run_cnt_d   = '0;
            drain_cnt_d = '0;
            flush_d     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid && start_ready_s) begin
                        state_d = ST_LOAD;
                        load_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    run_cnt_d = '0;
                    state_d   = ST_RUN;
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_RUN;
                    end else if (run_cnt_q == RUN_LAST) begin
                        state_d     = ST_DRAIN;
                        run_cnt_d   = '0;
                        drain_cnt_d = '0;
                        capture_d   = (DRAIN_LAST == '0);
                    end else begin
                        run_cnt_d = run_cnt_q + INPUT_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    // Capture strobe is pre-computed so it lands on the last drain cycle.
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d     = ST_HOLD;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_nxt_s;
                        capture_d   = (drain_nxt_s == DRAIN_LAST);
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        job_cnt_d = job_cnt_q + JOB_W'(1);
                        if (start_valid) begin
                            state_d = ST_LOAD;
                            load_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    run_cnt_d   = '0;
                    drain_cnt_d = '0;
                end
            endcase
        end

        out_valid_d = (state_d == ST_HOLD);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, counters and registered strobes/status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            run_cnt_q   <= '0;
            drain_cnt_q <= '0;
            job_cnt_q   <= '0;
            load_q      <= 1'b0;
            capture_q   <= 1'b0;
            flush_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            job_cnt_q   <= job_cnt_d;
            load_q      <= load_d;
            capture_q   <= capture_d;
            flush_q     <= flush_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign start_ready = start_ready_s;
    assign cell_enable = cell_enable_s;
    assign cell_load   = load_q;
    assign res_capture = capture_q;
    assign cell_flush  = flush_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign state_o     = state_q;
    assign job_cnt     = job_cnt_q;

endmodule

// File: tb/tb_tlut_seq_ctrl.sv
// Scoreboard bench for tlut_seq_ctrl: the driver predicts strobe/handshake cycles from
// sweep rules (count enabled cycles, add drain time); a monitor pops and compares.
module tb_tlut_seq_ctrl;

    localparam int IW      = 3;
    localparam int TL      = 2;
    localparam int JW      = 2;
    localparam int RUN_LEN = 1 << IW;
    localparam int JMOD    = 1 << JW;

    localparam int K_LOAD  = 0;
    localparam int K_CAP   = 1;
    localparam int K_VALID = 2;
    localparam int K_DONE  = 3;
    localparam int K_FLUSH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid, start_ready, pause, abort, out_ready, out_valid;
    logic          cell_load, cell_enable, cell_flush, res_capture, busy;
    logic [2:0]    state_o;
    logic [JW-1:0] job_cnt;

    tlut_seq_ctrl #(.INPUT_WIDTH(IW), .TREE_LAT(TL), .JOB_W(JW)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .pause(pause), .abort(abort), .out_ready(out_ready), .out_valid(out_valid),
        .cell_load(cell_load), .cell_enable(cell_enable), .cell_flush(cell_flush),
        .res_capture(res_capture), .busy(busy), .state_o(state_o), .job_cnt(job_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cyc;
        int jc;
    } ev_t;

    ev_t sbq[$];
    int  errors   = 0;
    int  checks   = 0;
    int  jc_model = 0;
    int  en_cnt   = 0;
    bit  prev_valid = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind);
        ev_t e;
        e.kind = kind;
        e.cyc  = (kind == K_FLUSH) ? cyc + 1 : cyc;
        e.jc   = jc_model;
        sbq.push_back(e);
    endtask

    // Monitor: pop an expected event whenever the DUT presents one.
    task automatic match(input int kind);
        ev_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
        end else begin
            e = sbq.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.cyc);
            if (kind == K_DONE || kind == K_FLUSH) check("job_cnt", int'(job_cnt), e.jc);
            if (kind == K_CAP) check("enable_cycles", en_cnt, RUN_LEN);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                en_cnt     = 0;
            end else begin
                check("busy", int'(busy), int'(state_o != 3'd0));
                check("out_valid_state", int'(out_valid), int'(state_o == 3'd4));
                check("start_ready", int'(start_ready),
                      int'(((state_o == 3'd0) || (state_o == 3'd4 && out_ready)) && !abort));
                check("cell_enable", int'(cell_enable), int'(state_o == 3'd2 && !pause));
                if (cell_enable) en_cnt++;
                if (cell_load) begin
                    en_cnt = 0;
                    match(K_LOAD);
                end
                if (cell_flush) match(K_FLUSH);
                if (res_capture) match(K_CAP);
                if (out_valid && !prev_valid) match(K_VALID);
                if (out_valid && out_ready && !abort) match(K_DONE);
                prev_valid = out_valid;
            end
        end
    end

    task automatic set_pause(input int h, input int plo, input int phi, input int ppct);
        pause = (((cyc - h) >= plo) && ((cyc - h) <= phi)) || ($urandom_range(0, 99) < ppct);
    endtask

    task automatic chk_abort(input int acyc, output bit ab);
        ab = 1'b0;
        if (cyc == acyc) begin
            abort = 1'b1;
            push(K_FLUSH);
            step();
            abort     = 1'b0;
            out_ready = 1'b0;
            pause     = 1'b0;
            ab        = 1'b1;
        end
    endtask

    // One job from the start-handshake cycle; returns inside the HOLD handshake cycle when chaining.
    task automatic run_job(input int plo, input int phi, input int ppct, input int abort_off,
                           input int rdy_wait, input bit chain, output bit chained);
        int h, acyc, en;
        bit ab;
        chained     = 1'b0;
        start_valid = 1'b1;
        h           = cyc;
        acyc        = (abort_off > 0) ? h + abort_off : -1;
        set_pause(h, plo, phi, ppct);
        step();
        start_valid = 1'b0;
        out_ready   = 1'b0;
        push(K_LOAD);
        set_pause(h, plo, phi, ppct);
        chk_abort(acyc, ab);
        if (ab) return;
        step();
        en = 0;
        while (en < RUN_LEN) begin
            set_pause(h, plo, phi, ppct);
            chk_abort(acyc, ab);
            if (ab) return;
            if (!pause) en++;
            step();
        end
        for (int i = 0; i <= TL; i++) begin
            set_pause(h, plo, phi, ppct);
            if (i == TL) push(K_CAP);
            chk_abort(acyc, ab);
            if (ab) return;
            step();
        end
        push(K_VALID);
        for (int w = 0; w < rdy_wait; w++) begin
            set_pause(h, plo, phi, ppct);
            chk_abort(acyc, ab);
            if (ab) return;
            step();
        end
        out_ready = 1'b1;
        chk_abort(acyc, ab);
        if (ab) return;
        push(K_DONE);
        jc_model = (jc_model + 1) % JMOD;
        if (chain) begin
            chained = 1'b1;
            return;
        end
        step();
        out_ready = 1'b0;
        pause     = 1'b0;
        repeat ($urandom_range(0, 3)) step();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, int'(state_o), 0);
        check({tag, "_start_ready"}, int'(start_ready), 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_job_cnt"}, int'(job_cnt), 0);
        check({tag, "_strobes"}, int'({cell_load, res_capture, cell_flush, cell_enable}), 0);
    endtask

    initial begin
        bit ch;
        int h;
        rst         = 1'b1;
        start_valid = 1'b0;
        pause       = 1'b0;
        abort       = 1'b0;
        out_ready   = 1'b0;
        #2;
        check_reset_vals("reset");
        step();
        step();
        rst = 1'b0;
        repeat (2) step();

        run_job(-1, -1, 0, 0, 2, 1'b0, ch);   // plain job
        run_job(4, 6, 0, 0, 0, 1'b0, ch);     // pause mid-sweep
        run_job(-1, -1, 0, 0, 1, 1'b1, ch);   // back-to-back
        run_job(-1, -1, 0, 0, 0, 1'b0, ch);
        run_job(-1, -1, 0, 6, 0, 1'b0, ch);   // abort in RUN
        step();
        run_job(-1, -1, 0, 15, 2, 1'b0, ch);  // abort together with out_ready in HOLD
        step();
        abort = 1'b1;                         // abort while idle: no flush
        step();
        abort = 1'b0;
        step();

        // Reset in the middle of DRAIN.
        start_valid = 1'b1;
        h           = cyc;
        step();
        start_valid = 1'b0;
        push(K_LOAD);
        repeat (10) step();
        rst = 1'b1;
        sbq.delete();
        jc_model = 0;
        #1;
        check_reset_vals("mid_drain_reset");
        step();
        rst = 1'b0;
        repeat (6) step();

        // Five completed jobs wrap a 2-bit counter to 1.
        for (int j = 0; j < 5; j++) run_job(-1, -1, 10, 0, j % 3, 1'b0, ch);
        check("job_cnt_wrap", int'(job_cnt), 1);

        for (int i = 0; i < 60; i++) begin
            int aoff;
            aoff = ($urandom_range(0, 99) < 25) ? int'($urandom_range(1, 20)) : 0;
            run_job(-1, -1, int'($urandom_range(0, 40)), aoff, int'($urandom_range(0, 4)),
                    (i < 59) && ($urandom_range(0, 2) == 0), ch);
        end
        out_ready   = 1'b0;
        start_valid = 1'b0;
        repeat (5) step();
        check("scoreboard_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
